// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite constants and the slave FSM state type.
//   HTRANS_*  : transfer type encodings
//   HRESP_*   : response encodings (AHB-Lite uses OKAY and ERROR only)
//   HSIZE_*   : log2(bytes) transfer size encodings
//   slave_state_t : data-phase state of ahb_sram_slave
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,      // no data phase pending, or final ready cycle of an OKAY transfer
        ST_WAIT,      // inserted wait cycles (hreadyout low)
        ST_RD_STALL,  // read waiting one cycle for the RAM port to be freed by a write
        ST_ERR1,      // first ERROR cycle (hreadyout low)
        ST_ERR2       // second ERROR cycle (hreadyout high)
    } slave_state_t;

endpackage

// File: rtl/sram_be_sp.sv
// Single-port synchronous SRAM with per-byte write enables.
//   clk   : clock
//   we    : byte-lane write enables (all zero = read)
//   addr  : word address
//   wdata : write data
//   q     : registered read data; on a write cycle it returns the merged
//           new word (write-first)
module sram_be_sp #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 65536,
    localparam int BYTES  = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [BYTES-1:0]  we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    // NOTE: RAM arrays carry no reset; clearing them would prevent mapping onto a RAM macro.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    // NOTE: assign a default before any conditional update so no latch is inferred.
    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        q <= merged;
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a byte-writable single-port SRAM.
//   hclk, hreset      : clock, synchronous active-high reset
//   hsel_s .. hwdata_s: AHB-Lite address/control and write data inputs
//   hreadyin_s        : bus-wide hready; a transfer is accepted only when high
//   hrdata_s          : read data, valid in the ready cycle of a read, else held
//   hreadyout_s       : slave ready (registered)
//   hresp_s           : OKAY / ERROR (registered)
// The RAM reads every cycle it is not writing, so a zero-wait read addressed
// straight from haddr_s has its data on q in the following (data-phase) cycle.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 65536,
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel_s,
    input  logic [ADDR_W-1:0] haddr_s,
    input  logic [1:0]        htrans_s,
    input  logic              hwrite_s,
    input  logic [2:0]        hsize_s,
    input  logic [2:0]        hburst_s,
    input  logic [DATA_W-1:0] hwdata_s,
    input  logic              hreadyin_s,
    output logic [DATA_W-1:0] hrdata_s,
    output logic              hreadyout_s,
    output logic [1:0]        hresp_s
);

    localparam int BYTES = DATA_W / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(DEPTH * BYTES);

    slave_state_t      state;
    logic [2:0]        wait_cnt;
    logic              dp_write;     // current data phase is an accepted write
    logic              dp_read;      // current data phase is an accepted read
    logic [AW-1:0]     addr_q;
    logic [BYTES-1:0]  be_q;
    logic [DATA_W-1:0] hrdata_hold;

    logic              accept;
    logic              bad;
    logic              wr_cycle;
    logic              collision;
    logic [AW-1:0]     ram_addr;
    logic [BYTES-1:0]  ram_we;
    logic [DATA_W-1:0] ram_q;

    // Lanes covered by a transfer of 2**size bytes starting at byte offset off.
    function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size,
                                                   input logic [BL-1:0] off);
        logic [BYTES-1:0] m;
        int n;
        n = 1 << int'(size);
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (i >= int'(off)) && (i < int'(off) + n);
        end
        return m;
    endfunction

    // New transfers are only taken while this slave shows ready.
    assign accept = ((state == ST_IDLE) || (state == ST_ERR2)) &&
                    hsel_s && hreadyin_s && htrans_s[1];

    // A size equal to the bus width gives an all-ones mask, forcing offset 0.
    assign bad = ({1'b0, haddr_s} >= BYTE_LIMIT) ||
                 (hsize_s > 3'(BL)) ||
                 ((haddr_s[BL-1:0] & ~({BL{1'b1}} << hsize_s)) != '0);

    // The ready cycle of a write is its RAM write cycle.
    assign wr_cycle  = dp_write && (state == ST_IDLE) && !hreset;
    assign collision = accept && !bad && !hwrite_s && wr_cycle;

    assign ram_we   = wr_cycle ? be_q : '0;
    assign ram_addr = (accept && !wr_cycle) ? haddr_s[BL +: AW] : addr_q;

    sram_be_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (hclk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (hwdata_s),
        .q     (ram_q)
    );

    assign hrdata_s = (dp_read && (state == ST_IDLE)) ? ram_q : hrdata_hold;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= ST_IDLE;
            hreadyout_s <= 1'b1;
            hresp_s     <= HRESP_OKAY;
            wait_cnt    <= '0;
            dp_write    <= 1'b0;
            dp_read     <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            hrdata_hold <= '0;
        end else begin
            hrdata_hold <= hrdata_s;
            case (state)
                ST_IDLE, ST_ERR2: begin
                    state       <= ST_IDLE;
                    hreadyout_s <= 1'b1;
                    hresp_s     <= HRESP_OKAY;
                    dp_write    <= 1'b0;
                    dp_read     <= 1'b0;
                    if (accept) begin
                        if (bad) begin
                            state       <= ST_ERR1;
                            hreadyout_s <= 1'b0;
                            hresp_s     <= HRESP_ERROR;
                        end else begin
                            addr_q   <= haddr_s[BL +: AW];
                            be_q     <= lane_mask(hsize_s, haddr_s[BL-1:0]);
                            dp_write <= hwrite_s;
                            dp_read  <= !hwrite_s;
                            if (collision) begin
                                state       <= ST_RD_STALL;
                                hreadyout_s <= 1'b0;
                            end else if (WAIT_STATES > 0) begin
                                state       <= ST_WAIT;
                                hreadyout_s <= 1'b0;
                                wait_cnt    <= 3'(WAIT_STATES - 1);
                            end
                        end
                    end
                end
                // The stall cycle counts as the first wait cycle.
                ST_RD_STALL: begin
                    if (WAIT_STATES > 1) begin
                        state    <= ST_WAIT;
                        wait_cnt <= 3'(WAIT_STATES - 2);
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_s <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= ST_IDLE;
                        hreadyout_s <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_s <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_s <= 1'b1;
                    hresp_s     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Burst type and the BUSY/IDLE distinction do not affect this slave.
    logic unused_inputs;
    assign unused_inputs = ^{htrans_s[0], hburst_s};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: a zero-wait instance (dut0) and a
// three-wait instance (dut3) share the master signals; hsel picks the target.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DEPTH  = 65536;

    logic              hclk = 1'b0;
    logic              hreset;
    logic              hsel0, hsel3;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [31:0]       hwdata;
    logic [31:0]       rdata0, rdata3;
    logic              rdy0, rdy3;
    logic [1:0]        resp0, resp3;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel_s(hsel0), .haddr_s(haddr), .htrans_s(htrans),
        .hwrite_s(hwrite), .hsize_s(hsize), .hburst_s(hburst), .hwdata_s(hwdata),
        .hreadyin_s(rdy0), .hrdata_s(rdata0), .hreadyout_s(rdy0), .hresp_s(resp0)
    );

    ahb_sram_slave #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hreset(hreset), .hsel_s(hsel3), .haddr_s(haddr), .htrans_s(htrans),
        .hwrite_s(hwrite), .hsize_s(hsize), .hburst_s(hburst), .hwdata_s(hwdata),
        .hreadyin_s(rdy3), .hrdata_s(rdata3), .hreadyout_s(rdy3), .hresp_s(resp3)
    );

    logic        use3;
    logic        cur_rdy;
    logic [1:0]  cur_resp;
    logic [31:0] cur_rdata;
    assign cur_rdy   = use3 ? rdy3   : rdy0;
    assign cur_resp  = use3 ? resp3  : resp0;
    assign cur_rdata = use3 ? rdata3 : rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic start_addr(input logic wr, input logic [ADDR_W-1:0] a,
                              input logic [2:0] sz, input logic [1:0] tr);
        hsel0  = !use3;
        hsel3  = use3;
        htrans = tr;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
    endtask

    task automatic bus_idle();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // One non-pipelined transfer; returns OR of resp over low cycles, final
    // resp, read data in the ready cycle and the number of low cycles.
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [1:0] resp_low,
                        output logic [1:0] resp_fin, output logic [31:0] rd, output int low);
        hburst = 3'b000;
        start_addr(wr, a, sz, HTRANS_NONSEQ);
        tick();
        bus_idle();
        hwdata   = wd;
        low      = 0;
        resp_low = HRESP_OKAY;
        while (!cur_rdy && low < 64) begin
            low++;
            resp_low = resp_low | cur_resp;
            tick();
        end
        resp_fin = cur_resp;
        rd       = cur_rdata;
        tick();
        hwdata = '0;
    endtask

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  resp;
        int          waits;
        logic        chk;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    logic [1:0]  rl, rf;
    logic [31:0] rd;
    int          low;
    logic [31:0] bdata [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 20'h00100, HSIZE_WORD,  32'h11223344, HRESP_OKAY,  0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 20'h00101, HSIZE_BYTE,  32'h0000AA00, HRESP_OKAY,  0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 20'h00100, HSIZE_WORD,  32'h0,        HRESP_OKAY,  0, 1'b1, 32'h1122AA44};
        vecs[3]  = '{1'b1, 20'h00200, HSIZE_WORD,  32'h55667788, HRESP_OKAY,  0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 20'h00202, HSIZE_HALF,  32'hBEEF0000, HRESP_OKAY,  0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 20'h00200, HSIZE_WORD,  32'h0,        HRESP_OKAY,  0, 1'b1, 32'hBEEF7788};
        vecs[6]  = '{1'b0, 20'h40000, HSIZE_WORD,  32'h0,        HRESP_ERROR, 1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 20'h00102, HSIZE_WORD,  32'h0BADF00D, HRESP_ERROR, 1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 20'h00108, HSIZE_DWORD, 32'h0,        HRESP_ERROR, 1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 20'h00101, HSIZE_HALF,  32'h00FFFF00, HRESP_ERROR, 1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 20'h00100, HSIZE_WORD,  32'h0,        HRESP_OKAY,  0, 1'b1, 32'h1122AA44};
        vecs[11] = '{1'b1, 20'h3FFFC, HSIZE_WORD,  32'hCAFEF00D, HRESP_OKAY,  0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 20'h3FFFF, HSIZE_BYTE,  32'h99000000, HRESP_OKAY,  0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 20'h3FFFC, HSIZE_WORD,  32'h0,        HRESP_OKAY,  0, 1'b1, 32'h99FEF00D};
        vecs[14] = '{1'b0, 20'hFFFFC, HSIZE_WORD,  32'h0,        HRESP_ERROR, 1, 1'b0, 32'h0};
        for (int i = 0; i < 4; i++) bdata[i] = 32'hA5000000 | (32'(i) << 8) | 32'h3C;

        // Reset
        use3 = 1'b0;
        bus_idle();
        haddr = '0; hwrite = 1'b0; hsize = HSIZE_WORD; hburst = 3'b000; hwdata = '0;
        hreset = 1'b1;
        tick();
        tick();
        hreset = 1'b0;
        check("reset_rdy0", 32'(rdy0), 32'd1);
        check("reset_resp0", 32'(resp0), 32'(HRESP_OKAY));
        check("reset_rdata0", rdata0, 32'h0);
        check("reset_rdy3", 32'(rdy3), 32'd1);
        check("reset_resp3", 32'(resp3), 32'(HRESP_OKAY));
        check("reset_rdata3", rdata3, 32'h0);
        tick();

        // Table of single transfers on the zero-wait instance
        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rl, rf, rd, low);
            check($sformatf("vec%0d_resp", i), 32'(rf), 32'(vecs[i].resp));
            check($sformatf("vec%0d_waits", i), 32'(low), 32'(vecs[i].waits));
            if (vecs[i].waits > 0) check($sformatf("vec%0d_resp_low", i), 32'(rl), 32'(vecs[i].resp));
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end

        // Write immediately followed by read of the same word: one stall cycle
        start_addr(1'b1, 20'h00100, HSIZE_WORD, HTRANS_NONSEQ);
        tick();
        hwdata = 32'hDEADBEEF;
        start_addr(1'b0, 20'h00100, HSIZE_WORD, HTRANS_NONSEQ);
        check("coll_write_ready", 32'(rdy0), 32'd1);
        tick();
        bus_idle();
        check("coll_stall_rdy", 32'(rdy0), 32'd0);
        check("coll_stall_resp", 32'(resp0), 32'(HRESP_OKAY));
        check("coll_stall_hold", rdata0, 32'h99FEF00D);
        tick();
        check("coll_read_rdy", 32'(rdy0), 32'd1);
        check("coll_read_data", rdata0, 32'hDEADBEEF);
        tick();
        hwdata = '0;
        check("coll_after_hold", rdata0, 32'hDEADBEEF);

        // INCR4 write burst on the three-wait instance
        use3   = 1'b1;
        hburst = 3'b011;
        start_addr(1'b1, 20'h00300, HSIZE_WORD, HTRANS_NONSEQ);
        tick();
        for (int i = 0; i < 4; i++) begin
            hwdata = bdata[i];
            if (i < 3) start_addr(1'b1, 20'(32'h300 + 4 * (i + 1)), HSIZE_WORD, HTRANS_SEQ);
            else       bus_idle();
            low = 0;
            rl  = HRESP_OKAY;
            while (!cur_rdy && low < 64) begin
                low++;
                rl = rl | cur_resp;
                tick();
            end
            check($sformatf("burst%0d_waits", i), 32'(low), 32'd3);
            check($sformatf("burst%0d_resp", i), 32'(rl | cur_resp), 32'(HRESP_OKAY));
            tick();
        end
        hwdata = '0;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 20'(32'h300 + 4 * i), HSIZE_WORD, 32'h0, rl, rf, rd, low);
            check($sformatf("burst_rd%0d_waits", i), 32'(low), 32'd3);
            check($sformatf("burst_rd%0d_data", i), rd, bdata[i]);
        end

        // Collision with wait states: stall overlaps the wait count
        start_addr(1'b1, 20'h00310, HSIZE_WORD, HTRANS_NONSEQ);
        tick();
        bus_idle();
        hwdata = 32'h5A5A1234;
        low = 0;
        while (!cur_rdy && low < 64) begin low++; tick(); end
        check("coll3_write_waits", 32'(low), 32'd3);
        start_addr(1'b0, 20'h00310, HSIZE_WORD, HTRANS_NONSEQ);
        tick();
        bus_idle();
        low = 0;
        while (!cur_rdy && low < 64) begin low++; tick(); end
        check("coll3_read_waits", 32'(low), 32'd3);
        check("coll3_read_data", rdata3, 32'h5A5A1234);
        tick();
        hwdata = '0;

        // Reset during a wait state of a write aborts it
        xfer(1'b1, 20'h00320, HSIZE_WORD, 32'h01020304, rl, rf, rd, low);
        check("rst_pre_write_waits", 32'(low), 32'd3);
        start_addr(1'b1, 20'h00320, HSIZE_WORD, HTRANS_NONSEQ);
        tick();
        bus_idle();
        hwdata = 32'hFFFFFFFF;
        tick();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check("rst_mid_rdy", 32'(rdy3), 32'd1);
        check("rst_mid_resp", 32'(resp3), 32'(HRESP_OKAY));
        check("rst_mid_rdata", rdata3, 32'h0);
        tick();
        tick();
        hwdata = '0;
        xfer(1'b0, 20'h00320, HSIZE_WORD, 32'h0, rl, rf, rd, low);
        check("rst_target_waits", 32'(low), 32'd3);
        check("rst_target_data", rd, 32'h01020304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
